// File: rtl/ro_measure_sequencer_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HDR   = 3'd4,
    ST_SEND  = 3'd5,
    ST_GAP   = 3'd6
  } ro_state_e;

  localparam logic [7:0] RO_HDR_BYTE = 8'hA5;

  // Width that holds 0..n; a zero-length count still needs one bit.
  function automatic int ro_timer_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter that saturates at zero; zero flags the terminal count.
module ro_window_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Sequences one ring-oscillator measurement window and ships the latched count over UART.
// Optional feature: define RO_SEQ_HEADER_EN to prefix each result with a header byte.
module ro_measure_sequencer
  import ro_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic [7:0] latch_count,
  input  logic       tx_ready,
  output logic       ro_en,
  output logic       cnt_clr,
  output logic       window_done,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy
);

  localparam int WIN_W = ro_timer_w(WINDOW_CYCLES);
  localparam int GAP_W = ro_timer_w(GAP_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ro_state_e state_q;
  ro_state_e state_d;
  logic      win_zero;
  logic      gap_zero;
  logic      win_load;
  logic      win_en;
  logic      gap_load;
  logic      gap_en;

  // Timer is loaded during CLEAR so GATE sees WINDOW_CYCLES-1 .. 0.
  assign win_load = (state_q == ST_CLEAR);
  assign win_en   = (state_q == ST_GATE);
  assign gap_load = (state_q == ST_SEND) && tx_ready;
  assign gap_en   = (state_q == ST_GAP);

  ro_window_timer #(
    .CNT_W (WIN_W)
  ) u_window_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (win_load),
    .load_val (WIN_LOAD),
    .en       (win_en),
    .zero     (win_zero)
  );

  ro_window_timer #(
    .CNT_W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start || continuous) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_GATE;
      ST_GATE:  if (win_zero) state_d = ST_LATCH;
`ifdef RO_SEQ_HEADER_EN
      ST_LATCH: state_d = ST_HDR;
`else
      ST_LATCH: state_d = ST_SEND;
`endif
      ST_HDR:   if (tx_ready) state_d = ST_SEND;
      ST_SEND: begin
        // A zero-length gap hands straight back to the continuous decision.
        if (tx_ready) begin
          if (GAP_CYCLES > 0) state_d = ST_GAP;
          else                state_d = continuous ? ST_CLEAR : ST_IDLE;
        end
      end
      ST_GAP:   if (gap_zero) state_d = continuous ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    ro_en       = 1'b0;
    cnt_clr     = 1'b0;
    window_done = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_CLEAR: cnt_clr     = 1'b1;
      ST_GATE:  ro_en       = 1'b1;
      ST_LATCH: window_done = 1'b1;
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = RO_HDR_BYTE;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = latch_count;
      end
      default: ;
    endcase
  end

endmodule
